// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the fetch -> decode instruction queue.
package fetch_buffer_pkg;

    localparam int DEF_ADDR_W  = 64;
    localparam int DEF_INSTR_W = 32;

    // Presented to decode whenever the queue is empty.
    localparam logic [DEF_INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instruction;
        logic [DEF_ADDR_W-1:0]  pc;
        logic [DEF_ADDR_W-1:0]  pc_link;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-side and decode-side handshake bundle of the fetch buffer.
interface fetch_buffer_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instruction;
    logic [ADDR_W-1:0]  in_pc;
    logic [ADDR_W-1:0]  in_pc_link;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instruction;
    logic [ADDR_W-1:0]  out_pc;
    logic [ADDR_W-1:0]  out_pc_link;

    // Fetch and decode stages (or a bench standing in for them).
    modport master (
        output in_valid, in_instruction, in_pc, in_pc_link, out_ready,
        input  in_ready, out_valid, out_instruction, out_pc, out_pc_link
    );

    // The buffer itself.
    modport slave (
        input  in_valid, in_instruction, in_pc, in_pc_link, out_ready,
        output in_ready, out_valid, out_instruction, out_pc, out_pc_link
    );
endinterface

// File: rtl/fetch_buffer_ctrl.sv
// Pointer and occupancy control for the fetch buffer: push/pop/flush priority.
module fetch_buffer_ctrl #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic             push,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop;

    // Handshake readiness comes only from registered occupancy, so there is
    // no combinational path from out_ready/in_valid to in_ready.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;

    // Next-state: flush clears everything and discards same-cycle push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset wins over flush, push and pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction queue between fetch and decode; in_ready drives fetch PCWrite.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int PTR_W   = $clog2(DEPTH),
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    fetch_buffer_if.slave      bus,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     head;
    logic             push;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    fetch_buffer_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .out_ready (bus.out_ready),
        .in_ready  (bus.in_ready),
        .out_valid (bus.out_valid),
        .push      (push),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count)
    );

    // Entry storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr].instruction <= bus.in_instruction;
            mem_q[wr_ptr].pc          <= bus.in_pc;
            mem_q[wr_ptr].pc_link     <= bus.in_pc_link;
        end
    end

    // Head read straight from storage; an empty queue shows a NOP at PC 0.
    always_comb begin
        head = mem_q[rd_ptr];
        if (!bus.out_valid) begin
            head.instruction = NOP_INSTR;
            head.pc          = '0;
            head.pc_link     = '0;
        end
    end

    assign bus.out_instruction = head.instruction;
    assign bus.out_pc          = head.pc;
    assign bus.out_pc_link     = head.pc_link;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: fill/drain, streaming, full+pop, flush, reset.
module tb_fetch_buffer;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'hD503201F;

    logic       clock = 1'b0;
    logic       reset;
    logic       flush;
    logic [2:0] count;
    int         errors = 0;
    int         checks = 0;
    bit         inv_on = 1'b0;

    fetch_buffer_if #(.ADDR_W(64), .INSTR_W(32)) bus ();

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave),
        .count (count)
    );

    always #5 clock = ~clock;

    // Occupancy invariant, sampled on the falling edge.
    always @(negedge clock) begin
        if (inv_on && !reset) begin
            logic [1:0] diff;
            diff = dut.u_ctrl.wr_ptr_q - dut.u_ctrl.rd_ptr_q;
            checks++;
            if (count > 3'(DEPTH) ||
                (count == 3'(DEPTH) ? diff != 2'd0 : 3'(diff) != count)) begin
                errors++;
                $display("FAIL invariant: count=%0d wr-rd=%0d", count, diff);
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit v, input logic [63:0] pc);
        bus.in_valid       = v;
        bus.in_pc          = pc;
        bus.in_pc_link     = pc + 64'd4;
        bus.in_instruction = 32'hA000_0000 | pc[31:0];
    endtask

    task automatic do_reset;
        reset = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 64'd0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        inv_on = 1'b1;
        checks += 6;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        if (bus.out_instruction !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", bus.out_instruction, NOP); end
        if (bus.out_pc !== 64'd0) begin errors++; $display("FAIL reset_pc: got %h want 0", bus.out_pc); end
        if (bus.out_pc_link !== 64'd0) begin errors++; $display("FAIL reset_link: got %h want 0", bus.out_pc_link); end
    endtask

    task automatic test_fill_drain;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'(4 * i));
            tick();
            checks++;
            if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b want 0", bus.in_ready); end
        drive(1'b1, 64'h10);
        tick();
        checks += 2;
        if (count !== 3'd4) begin errors++; $display("FAIL fill_fifth_count: got %0d want 4", count); end
        if (bus.out_pc !== 64'h0) begin errors++; $display("FAIL fill_head: got %h want 0", bus.out_pc); end
        drive(1'b0, 64'h10);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks += 4;
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d]: got %b want 1", i, bus.out_valid); end
            if (bus.out_pc !== 64'(4 * i)) begin errors++; $display("FAIL drain_pc[%0d]: got %h want %h", i, bus.out_pc, 4 * i); end
            if (bus.out_pc_link !== 64'(4 * i + 4)) begin errors++; $display("FAIL drain_link[%0d]: got %h want %h", i, bus.out_pc_link, 4 * i + 4); end
            if (bus.out_instruction !== (32'hA000_0000 | 32'(4 * i))) begin errors++; $display("FAIL drain_instr[%0d]: got %h", i, bus.out_instruction); end
            tick();
        end
        checks += 2;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", bus.out_valid); end
        if (bus.out_instruction !== NOP) begin errors++; $display("FAIL drain_nop: got %h want %h", bus.out_instruction, NOP); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_streaming;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 64'h100 + 64'(4 * k));
            tick();
            checks += 2;
            if (count !== 3'd1) begin errors++; $display("FAIL stream_count[%0d]: got %0d want 1", k, count); end
            if (bus.out_pc !== 64'h100 + 64'(4 * k)) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", k, bus.out_pc, 64'h100 + 64'(4 * k)); end
        end
        drive(1'b0, 64'h0);
        tick();
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL stream_end_count: got %0d want 0", count); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_full_pop;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h200 + 64'(4 * i));
            tick();
        end
        checks++;
        if (count !== 3'd4) begin errors++; $display("FAIL fullpop_fill: got %0d want 4", count); end
        drive(1'b1, 64'h210);
        bus.out_ready = 1'b1;
        tick();
        checks += 2;
        if (count !== 3'd3) begin errors++; $display("FAIL fullpop_count: got %0d want 3", count); end
        if (bus.out_pc !== 64'h204) begin errors++; $display("FAIL fullpop_head: got %h want 204", bus.out_pc); end
        bus.out_ready = 1'b0;
        tick();
        checks++;
        if (count !== 3'd4) begin errors++; $display("FAIL fullpop_accept: got %0d want 4", count); end
        drive(1'b0, 64'h0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.out_pc !== 64'h204 + 64'(4 * i)) begin errors++; $display("FAIL fullpop_drain[%0d]: got %h want %h", i, bus.out_pc, 64'h204 + 64'(4 * i)); end
            tick();
        end
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL fullpop_empty: got %0d want 0", count); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_flush;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h300 + 64'(4 * i));
            tick();
        end
        drive(1'b1, 64'h30C);
        bus.out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 64'h0);
        checks += 4;
        if (count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", bus.in_ready); end
        if (bus.out_pc !== 64'h0) begin errors++; $display("FAIL flush_pc: got %h want 0", bus.out_pc); end
        drive(1'b1, 64'h400);
        tick();
        drive(1'b0, 64'h0);
        checks += 3;
        if (bus.out_pc !== 64'h400) begin errors++; $display("FAIL flush_repush_pc: got %h want 400", bus.out_pc); end
        if (bus.out_pc_link !== 64'h404) begin errors++; $display("FAIL flush_repush_link: got %h want 404", bus.out_pc_link); end
        if (count !== 3'd1) begin errors++; $display("FAIL flush_repush_count: got %0d want 1", count); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset_over_flush;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 64'h500 + 64'(4 * i));
            tick();
        end
        checks++;
        if (count !== 3'd2) begin errors++; $display("FAIL rof_fill: got %0d want 2", count); end
        drive(1'b1, 64'h508);
        bus.out_ready = 1'b1;
        reset = 1'b1;
        flush = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 64'h0);
        checks += 4;
        if (count !== 3'd0) begin errors++; $display("FAIL rof_count: got %0d want 0", count); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rof_out_valid: got %b want 0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rof_in_ready: got %b want 1", bus.in_ready); end
        if (bus.out_instruction !== NOP) begin errors++; $display("FAIL rof_instr: got %h want %h", bus.out_instruction, NOP); end
        drive(1'b1, 64'h600);
        tick();
        drive(1'b0, 64'h0);
        checks += 2;
        if (count !== 3'd1) begin errors++; $display("FAIL rof_push_count: got %0d want 1", count); end
        if (bus.out_pc !== 64'h600) begin errors++; $display("FAIL rof_push_pc: got %h want 600", bus.out_pc); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL rof_pop_count: got %0d want 0", count); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_streaming();
        test_full_pop();
        test_flush();
        test_reset_over_flush();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Small instruction queue between instruction fetch and decode.
- Captures {instruction, PC, PC+4 link value} triples each cycle fetch presents one, and hands them to decode with a valid/ready handshake.
- Decouples decode stalls from the PC register: in_ready drives fetch's PCWrite.
- Supports single-cycle flush on taken branch / branch-register redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- ADDR_W, 64, PC width
- INSTR_W, 32, instruction width

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  fetch presents a valid entry this cycle
- in_ready  output  1  buffer accepts an entry this cycle; drives fetch PCWrite
- in_instruction  input  INSTR_W  fetched instruction
- in_pc  input  ADDR_W  PC of fetched instruction
- in_pc_link  input  ADDR_W  PC+4 (branch-link value)
- flush  input  1  discard all entries (branch redirect)
- out_valid  output  1  head entry valid for decode
- out_ready  input  1  decode consumes head this cycle (not stalled)
- out_instruction  output  INSTR_W  head instruction, or NOP when empty
- out_pc  output  ADDR_W  head PC, 0 when empty
- out_pc_link  output  ADDR_W  head link value, 0 when empty
- count  output  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (clock edge with reset=1):
  - wr_ptr = rd_ptr = count = 0.
  - Storage contents are don't-care.
  - Outputs after reset: out_valid=0, in_ready=1, out_instruction=NOP (32'hD503201F), out_pc=0, out_pc_link=0.
  - Reset overrides flush, push and pop.
- Push = in_valid & in_ready. Pop = out_valid & out_ready. Both are evaluated on the rising edge.
- in_ready = (count != DEPTH).
  - Depends only on registered state; no combinational path from out_ready or in_valid.
- out_valid = (count != 0).
  - The head is read combinationally from storage[rd_ptr].
  - When empty, out_instruction=NOP and out_pc/out_pc_link=0.
- Latency: an entry pushed at edge N is visible at the outputs after edge N. There is no same-cycle bypass from input to output.
- Push only: write storage[wr_ptr], wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1.
- Simultaneous push and pop: both pointers advance and count is unchanged.
  - Legal when 0 < count < DEPTH.
  - When full, in_ready=0, so no push occurs; a pop alone frees one entry for the next cycle.
  - When empty, out_valid=0, so no pop occurs; the push alone fills one entry.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH naturally.
- Flush (reset=0, flush=1):
  - Next state: wr_ptr = rd_ptr = count = 0.
  - Any same-cycle push and pop are discarded; flush has priority.
  - The cycle after a flush, out_valid=0 and in_ready=1.
- in_valid may drop while in_ready=0; no entry is lost or duplicated.
- Input fields are sampled only on the push edge.
- Invariant: count never exceeds DEPTH and never underflows. The bench asserts count == (wr_ptr - rd_ptr) mod DEPTH, with full vs empty disambiguated by count.

Decomposition:
- Shared package holds:
  - NOP_INSTR = 32'hD503201F
  - ADDR_W / INSTR_W defaults
  - fetch_entry typedef {instruction, pc, pc_link}
- Storage is an array of fetch_entry held inline.
- One sub-module is natural: fetch_buffer_ctrl, holding pointers, count, push/pop/flush priority, in_ready and out_valid. The top level holds storage and the output mux.

Test Plan:
- Reset then idle: after reset, expect out_valid=0, in_ready=1, count=0, out_instruction=32'hD503201F, out_pc=0.
- Fill, then drain:
  - Push PCs 0x0,0x4,0x8,0xC with out_ready=0. Expect count 1..4, then in_ready=0; a 5th in_valid (PC 0x10) is not accepted.
  - Then out_ready=1. Expect out_pc 0x0,0x4,0x8,0xC on consecutive cycles with out_pc_link = out_pc+4, followed by out_valid=0.
- Streaming:
  - in_valid=1 and out_ready=1 continuously for 10 cycles (PC 0x100 upward).
  - Expect count to stay at 1 after the first cycle, out_pc to lag in_pc by one cycle, and pointers to wrap past DEPTH with no loss.
- Full with simultaneous pop:
  - At count=4, assert in_valid and out_ready.
  - Expect pop only: count=3, and the pending entry is accepted the following cycle.
- Flush mid-stream:
  - At count=3, assert flush, in_valid and out_ready together.
  - Next cycle expect count=0, out_valid=0, in_ready=1.
  - Then push PC 0x400 and expect out_pc=0x400 next cycle.
- Reset over flush: assert reset and flush with count=2. Expect the reset state, and the next push behaves as from empty.
